pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register, the generalised successor to the per-stage IF/ID, ID/EX, EX/MEM and MEM/WB latches. It carries an opaque data payload plus a control field through one stage with a valid/ready handshake, synchronous flush and bubble insertion. An optional skid entry sustains full throughput under downstream backpressure. One instance sits between each pair of adjacent pipeline stages of the five-stage CPU.

---
 rtl/pipe_pkg.sv | 69 ++++++
 rtl/pipe_skid_slot.sv | 44 ++++
 rtl/pipe_stage_reg.sv | 97 +++++++++
 tb/tb_pipe_stage_reg.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-register constants: default control width, the idle (NOP) control value
// and the bit layout of the control field, so every stage packs and unpacks it identically.
package pipe_pkg;

  localparam int PIPE_CTRL_W = 16;
  localparam logic [PIPE_CTRL_W-1:0] PIPE_CTRL_IDLE = '0;

  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_READ   = 1;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_ALU_SRC_A  = 3;
  localparam int CTRL_ALU_SRC_B  = 4;
  localparam int CTRL_REG_DST    = 5;
  localparam int CTRL_MEM_TO_REG = 6;
  localparam int CTRL_SIGN       = 7;
  localparam int CTRL_IS_BRANCH  = 8;
  localparam int CTRL_ALU_OP_LSB = 9;
  localparam int CTRL_ALU_OP_W   = 4;

  typedef struct packed {
    logic [CTRL_ALU_OP_W-1:0] alu_op;
    logic                     is_branch;
    logic                     sign;
    logic                     mem_to_reg;
    logic                     reg_dst;
    logic                     alu_src_b;
    logic                     alu_src_a;
    logic                     mem_write;
    logic                     mem_read;
    logic                     reg_write;
  } ctrl_fields_t;

  function automatic logic [PIPE_CTRL_W-1:0] pack_ctrl(input ctrl_fields_t f);
    logic [PIPE_CTRL_W-1:0] c;
    c = PIPE_CTRL_IDLE;
    c[CTRL_REG_WRITE]  = f.reg_write;
    c[CTRL_MEM_READ]   = f.mem_read;
    c[CTRL_MEM_WRITE]  = f.mem_write;
    c[CTRL_ALU_SRC_A]  = f.alu_src_a;
    c[CTRL_ALU_SRC_B]  = f.alu_src_b;
    c[CTRL_REG_DST]    = f.reg_dst;
    c[CTRL_MEM_TO_REG] = f.mem_to_reg;
    c[CTRL_SIGN]       = f.sign;
    c[CTRL_IS_BRANCH]  = f.is_branch;
    c[CTRL_ALU_OP_LSB +: CTRL_ALU_OP_W] = f.alu_op;
    return c;
  endfunction

  function automatic ctrl_fields_t unpack_ctrl(input logic [PIPE_CTRL_W-1:0] c);
    ctrl_fields_t f;
    f.reg_write  = c[CTRL_REG_WRITE];
    f.mem_read   = c[CTRL_MEM_READ];
    f.mem_write  = c[CTRL_MEM_WRITE];
    f.alu_src_a  = c[CTRL_ALU_SRC_A];
    f.alu_src_b  = c[CTRL_ALU_SRC_B];
    f.reg_dst    = c[CTRL_REG_DST];
    f.mem_to_reg = c[CTRL_MEM_TO_REG];
    f.sign       = c[CTRL_SIGN];
    f.is_branch  = c[CTRL_IS_BRANCH];
    f.alu_op     = c[CTRL_ALU_OP_LSB +: CTRL_ALU_OP_W];
    return f;
  endfunction

  // True when the control word can change architectural state.
  function automatic logic ctrl_has_side_effect(input logic [PIPE_CTRL_W-1:0] c);
    return c[CTRL_REG_WRITE] | c[CTRL_MEM_WRITE] | c[CTRL_IS_BRANCH];
  endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One pipeline entry: a valid bit plus payload/control registers with load and drop.
// Control reads as CTRL_IDLE whenever the entry is invalid; dropping keeps the payload.
module pipe_skid_slot
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = 64,
  parameter int                CTRL_W    = PIPE_CTRL_W,
  parameter logic [CTRL_W-1:0] CTRL_IDLE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              drop,
  input  logic [DATA_W-1:0] load_data,
  input  logic [CTRL_W-1:0] load_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [CTRL_W-1:0] ctrl_q;

  // load wins over drop: a draining entry refilled in the same cycle stays valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= CTRL_IDLE;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= load_data;
      ctrl_q  <= load_ctrl;
    end else if (drop) begin
      valid_q <= 1'b0;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign ctrl  = valid_q ? ctrl_q : CTRL_IDLE;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush, bubble insertion and an
// optional skid entry that keeps in_ready free of any combinational path from out_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = 64,
  parameter int                CTRL_W    = PIPE_CTRL_W,
  parameter logic [CTRL_W-1:0] CTRL_IDLE = '0,
  parameter int                SKID      = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  input  logic              bubble,
  output logic [1:0]        occ
);

  logic              xfer_in;
  logic              xfer_out;
  logic              main_valid;
  logic              main_load;
  logic              main_drop;
  logic [DATA_W-1:0] main_src_data;
  logic [CTRL_W-1:0] main_src_ctrl;
  logic              skid_valid;
  logic              skid_load;
  logic              skid_drop;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  assign in_ready = (SKID != 0) ? !skid_valid : (!main_valid || out_ready);
  assign xfer_in  = in_valid && in_ready && !bubble;
  assign xfer_out = main_valid && out_ready;

  // The skid entry is only ever filled behind a valid main entry, so it always drains first.
  assign main_load     = !flush && (!main_valid || xfer_out) && (skid_valid || xfer_in);
  assign main_drop     = flush || xfer_out;
  assign main_src_data = skid_valid ? skid_data : in_data;
  assign main_src_ctrl = skid_valid ? skid_ctrl : in_ctrl;

  pipe_skid_slot #(
    .DATA_W    (DATA_W),
    .CTRL_W    (CTRL_W),
    .CTRL_IDLE (CTRL_IDLE)
  ) u_main (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (main_load),
    .drop      (main_drop),
    .load_data (main_src_data),
    .load_ctrl (main_src_ctrl),
    .valid     (main_valid),
    .data      (out_data),
    .ctrl      (out_ctrl)
  );

  generate
    if (SKID != 0) begin : g_skid
      assign skid_load = !flush && xfer_in && main_valid && !xfer_out;
      assign skid_drop = flush || (skid_valid && xfer_out);

      pipe_skid_slot #(
        .DATA_W    (DATA_W),
        .CTRL_W    (CTRL_W),
        .CTRL_IDLE (CTRL_IDLE)
      ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (skid_load),
        .drop      (skid_drop),
        .load_data (in_data),
        .load_ctrl (in_ctrl),
        .valid     (skid_valid),
        .data      (skid_data),
        .ctrl      (skid_ctrl)
      );
    end else begin : g_no_skid
      assign skid_load  = 1'b0;
      assign skid_drop  = 1'b0;
      assign skid_valid = 1'b0;
      assign skid_data  = '0;
      assign skid_ctrl  = CTRL_IDLE;
    end
  endgenerate

  assign out_valid = main_valid;
  assign occ       = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one SKID=0 and one SKID=1 instance share stimulus; a directed
// vector table targets the SKID=1 instance, and a per-instance scoreboard tracks both.
module tb_pipe_stage_reg;

  localparam int DW = 64;
  localparam int CW = 16;

  typedef logic [DW+CW-1:0] ent_t;

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          bub;
    logic          fl;
    logic          eov;
    logic [DW-1:0] eod;
    logic [1:0]    eocc;
    logic          eir;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          out_ready;
  logic          bubble;
  logic          flush;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;

  logic          rdy0, rdy1, ov0, ov1;
  logic [DW-1:0] od0, od1;
  logic [CW-1:0] oc0, oc1;
  logic [1:0]    occ0, occ1;

  int   checks = 0;
  int   failures = 0;
  vec_t tbl[$];
  vec_t exp_row;
  logic exp_on = 1'b0;
  ent_t sb_q[2][$];

  function automatic logic [CW-1:0] ctrl_of(input logic [DW-1:0] d);
    return d[15:0] ^ d[31:16] ^ 16'h5A3C;
  endfunction

  assign in_ctrl = ctrl_of(in_data);

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_IDLE('0), .SKID(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
    .in_ctrl(in_ctrl), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
    .out_ctrl(oc0), .flush(flush), .bubble(bubble), .occ(occ0)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_IDLE('0), .SKID(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
    .in_ctrl(in_ctrl), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .out_ctrl(oc1), .flush(flush), .bubble(bubble), .occ(occ1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic bub,
                     input logic fl, input logic eov, input logic [DW-1:0] eod,
                     input logic [1:0] eocc, input logic eir);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.bub = bub; v.fl = fl;
    v.eov = eov; v.eod = eod; v.eocc = eocc; v.eir = eir;
    tbl.push_back(v);
  endtask

  // Monitor: state is stable and inputs settled on the falling edge.
  always @(negedge clk) begin
    logic          ov, rdy, exp_rdy;
    logic [DW-1:0] od;
    logic [CW-1:0] oc;
    logic [1:0]    oq;
    int            sz;
    ent_t          e;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) sb_q[k].delete();
      check("rst_u0_out_valid", ov0, 0);
      check("rst_u0_out_ctrl", oc0, 0);
      check("rst_u0_occ", occ0, 0);
      check("rst_u0_in_ready", rdy0, 1);
      check("rst_u1_out_valid", ov1, 0);
      check("rst_u1_out_ctrl", oc1, 0);
      check("rst_u1_occ", occ1, 0);
      check("rst_u1_in_ready", rdy1, 1);
    end else begin
      if (exp_on) begin
        check("tbl_out_valid", ov1, exp_row.eov);
        check("tbl_occ", occ1, exp_row.eocc);
        check("tbl_in_ready", rdy1, exp_row.eir);
        if (exp_row.eov) begin
          check("tbl_out_data", od1, exp_row.eod);
          check("tbl_out_ctrl", oc1, ctrl_of(exp_row.eod));
        end
      end
      for (int k = 0; k < 2; k++) begin
        ov  = (k == 0) ? ov0 : ov1;
        rdy = (k == 0) ? rdy0 : rdy1;
        od  = (k == 0) ? od0 : od1;
        oc  = (k == 0) ? oc0 : oc1;
        oq  = (k == 0) ? occ0 : occ1;
        sz  = sb_q[k].size();
        exp_rdy = (k == 0) ? ((sz == 0) || out_ready) : (sz < 2);
        check($sformatf("sb_u%0d_occ", k), oq, sz);
        check($sformatf("sb_u%0d_out_valid", k), ov, sz != 0);
        check($sformatf("sb_u%0d_in_ready", k), rdy, exp_rdy);
        if (!ov) check($sformatf("sb_u%0d_idle_ctrl", k), oc, 0);
        if (ov && out_ready && sz > 0) begin
          e = sb_q[k].pop_front();
          check($sformatf("sb_u%0d_out_data", k), od, e[DW+CW-1:CW]);
          check($sformatf("sb_u%0d_out_ctrl", k), oc, e[CW-1:0]);
        end
        if (flush) sb_q[k].delete();
        else if (in_valid && rdy && !bubble) sb_q[k].push_back({in_data, in_ctrl});
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; in_data = 64'hDEAD;
    out_ready = 1'b0; bubble = 1'b0; flush = 1'b0;

    // streaming, then idle
    for (int i = 1; i <= 8; i++) add(1, i, 1, 0, 0, 1, i, 1, 1);
    add(0, 0, 1, 0, 0, 0, 0, 0, 1);
    // bubble mid-stream, stalled input held upstream
    add(1, 'h11, 1, 0, 0, 1, 'h11, 1, 1);
    add(1, 'h12, 1, 0, 0, 1, 'h12, 1, 1);
    add(1, 'h13, 1, 1, 0, 0, 0, 0, 1);
    add(1, 'h13, 1, 0, 0, 1, 'h13, 1, 1);
    add(0, 0, 1, 0, 0, 0, 0, 0, 1);
    // backpressure fills main and skid
    add(1, 'hA, 0, 0, 0, 1, 'hA, 1, 1);
    add(1, 'hB, 0, 0, 0, 1, 'hA, 2, 0);
    add(1, 'hC, 0, 0, 0, 1, 'hA, 2, 0);
    add(1, 'hC, 1, 0, 0, 1, 'hB, 1, 1);
    add(1, 'hC, 1, 0, 0, 1, 'hC, 1, 1);
    add(0, 0, 1, 0, 0, 0, 0, 0, 1);
    // flush at occ=2, flush discarding an accepted input, flush with bubble
    add(1, 'h1A, 0, 0, 0, 1, 'h1A, 1, 1);
    add(1, 'h1B, 0, 0, 0, 1, 'h1A, 2, 0);
    add(1, 'hF, 0, 0, 1, 0, 0, 0, 1);
    add(1, 'h0F, 0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 0, 0, 1);
    add(1, 'h21, 0, 0, 0, 1, 'h21, 1, 1);
    add(1, 'h22, 0, 1, 1, 0, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 0, 0, 1);
    // toggling out_ready
    add(1, 'h31, 0, 0, 0, 1, 'h31, 1, 1);
    add(1, 'h32, 1, 0, 0, 1, 'h32, 1, 1);
    add(1, 'h33, 0, 0, 0, 1, 'h32, 2, 0);
    add(1, 'h34, 1, 0, 0, 1, 'h33, 1, 1);
    add(1, 'h34, 1, 0, 0, 1, 'h34, 1, 1);
    add(0, 0, 1, 0, 0, 0, 0, 0, 1);

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    in_valid = 1'b0;

    foreach (tbl[i]) begin
      in_valid = tbl[i].iv; in_data = tbl[i].d; out_ready = tbl[i].ordy;
      bubble = tbl[i].bub; flush = tbl[i].fl;
      @(posedge clk); #1;
      exp_row = tbl[i];
      exp_on = 1'b1;
    end
    @(posedge clk); #1;
    exp_on = 1'b0;

    // reset asserted mid-transfer clears everything without a clock edge
    in_valid = 1'b1; out_ready = 1'b0; in_data = 'h41;
    @(posedge clk); #1 in_data = 'h42;
    @(posedge clk); #1 rst_n = 1'b0; in_data = 'h43;
    @(posedge clk); #1 rst_n = 1'b1; in_valid = 1'b0;

    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 2) != 0);
      bubble    = ($urandom_range(0, 9) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      @(posedge clk); #1;
    end

    in_valid = 1'b0; out_ready = 1'b1; bubble = 1'b0; flush = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
